instruction_fetch: RTL and testbench



---
 rtl/ifetch_pkg.sv | 14 +
 rtl/instruction_fetch_if.sv | 14 +
 rtl/ifetch_next_pc.sv | 23 ++
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Pure declarations: no latency, no flow control.
package ifetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

    typedef logic [31:0] pc_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode instruction slot: valid/ready handshake carrying the word and its PC.
// Latency/backpressure are owned by the master; a word transfers when valid && ready.
interface instruction_fetch_if;

    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    modport master (output valid, output instr, output pc, output pc_plus4, input ready);
    modport slave  (input valid, input instr, input pc, input pc_plus4, output ready);

endinterface

// File: rtl/ifetch_next_pc.sv
// Next fetch address (redirect over pc+4) with alignment and memory-range check.
// Combinational, zero latency; no flow control of its own.
module ifetch_next_pc
    import ifetch_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  pc_t  pc,
    input  logic redirect_valid,
    input  pc_t  redirect_target,
    output pc_t  next_pc,
    output logic bad_addr
);

    // Compare in 34 bits so a memory spanning the full 4 GiB space cannot overflow the limit.
    localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) * 34'(WORD_BYTES);

    always_comb begin
        next_pc  = redirect_valid ? redirect_target : pc + pc_t'(WORD_BYTES);
        bad_addr = (next_pc[1:0] != 2'b00) || ({2'b00, next_pc} >= ADDR_LIMIT);
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC register, one-entry output slot, sticky fault on bad address; IFETCH_DELAY_SLOT_EN keeps the delay-slot word on redirect.
// Latency: word at pc appears on the slot one clock later; backpressure: slot and pc hold while valid && !ready.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter pc_t         RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output pc_t                        imem_addr,
    input  logic [31:0]                imem_data,
    instruction_fetch_if.master        out,
    input  logic                       redirect_valid,
    input  pc_t                        redirect_target,
    output logic                       fault,
    output pc_t                        fault_pc,
    output logic [31:0]                fetch_count
);

    state_t      state_q, state_d;
    pc_t         pc_q;
    pc_t         next_pc;
    logic        bad_addr;
    logic        slot_free;
    logic        pc_load;
    logic        capture;
    logic        squash;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    pc_t         out_pc_q;

    ifetch_next_pc #(
        .MEM_WORDS(MEM_WORDS)
    ) u_next_pc (
        .pc              (pc_q),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .next_pc         (next_pc),
        .bad_addr        (bad_addr)
    );

    assign slot_free = !out_valid_q || out.ready;

    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        capture = 1'b0;
        squash  = 1'b0;
        case (state_q)
            RUN: begin
                pc_load = redirect_valid || slot_free;
`ifdef IFETCH_DELAY_SLOT_EN
                capture = slot_free;
`else
                capture = slot_free && !redirect_valid;
                squash  = redirect_valid;
`endif
                if (pc_load && bad_addr) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            state_q <= state_d;
            // A bad next address freezes pc at the last good fetch.
            if (pc_load) begin
                if (bad_addr) begin
                    fault    <= 1'b1;
                    fault_pc <= next_pc;
                end else begin
                    pc_q <= next_pc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            fetch_count <= '0;
        end else begin
            if (capture) begin
                out_valid_q <= 1'b1;
                out_instr_q <= imem_data;
                out_pc_q    <= pc_q;
            end else if (squash || slot_free) begin
                out_valid_q <= 1'b0;
            end
            if (out_valid_q && out.ready) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr    = pc_q;
    assign out.valid    = out_valid_q;
    assign out.instr    = out_instr_q;
    assign out.pc       = out_pc_q;
    assign out.pc_plus4 = out_pc_q + pc_t'(WORD_BYTES);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed steps plus random ready/redirect traffic against a reference model.
module tb_instruction_fetch;

    localparam int MEM_WORDS = 1024;
`ifdef IFETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;
    logic [31:0] mem [0:MEM_WORDS-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch_if ifc ();

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .out             (ifc.master),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fault           (fault),
        .fault_pc        (fault_pc),
        .fetch_count     (fetch_count)
    );

    function automatic logic [31:0] mword(input logic [31:0] a);
        return (a < 32'(MEM_WORDS * 4)) ? mem[a[11:2]] : 32'h0;
    endfunction

    always_comb imem_data = mword(imem_addr);

    // Reference model: architectural fetch state plus the delivered slot.
    logic [31:0] m_pc, m_instr, m_opc, m_fpc, m_cnt;
    bit          m_valid, m_fault;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_opc = 32'h0; m_fpc = 32'h0; m_cnt = 32'h0;
        m_valid = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_step();
        bit     free;
        bit     moves;
        longint tgt;
        free = !m_valid || ifc.ready;
        if (m_valid && ifc.ready) m_cnt = m_cnt + 1;
        if (m_fault) begin
            if (ifc.ready) m_valid = 1'b0;
        end else begin
            tgt   = redirect_valid ? longint'(redirect_target) : longint'(m_pc) + 4;
            moves = redirect_valid || free;
            if (redirect_valid && !DS) begin
                m_valid = 1'b0;
            end else if (free) begin
                m_valid = 1'b1;
                m_instr = mword(m_pc);
                m_opc   = m_pc;
            end
            if (moves) begin
                if ((tgt % 4) != 0 || tgt >= longint'(MEM_WORDS) * 4) begin
                    m_fault = 1'b1;
                    m_fpc   = tgt[31:0];
                end else begin
                    m_pc = tgt[31:0];
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr",    imem_addr,     m_pc);
        chk("out_valid",    32'(ifc.valid), 32'(m_valid));
        chk("out_instr",    ifc.instr,     m_instr);
        chk("out_pc",       ifc.pc,        m_opc);
        chk("out_pc_plus4", ifc.pc_plus4,  m_opc + 32'd4);
        chk("fault",        32'(fault),    32'(m_fault));
        chk("fault_pc",     fault_pc,      m_fpc);
        chk("fetch_count",  fetch_count,   m_cnt);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int n;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;

        rst_n = 1'b0; ifc.ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from RESET_PC.
        tick(); chk("seq_pc0", ifc.pc, 32'h0); chk("seq_instr0", ifc.instr, 32'h2008_0001); chk("seq_cnt0", fetch_count, 32'd0);
        tick(); chk("seq_pc1", ifc.pc, 32'h4); chk("seq_instr1", ifc.instr, 32'h2009_0002); chk("seq_cnt1", fetch_count, 32'd1);
        tick(); chk("seq_pc2", ifc.pc, 32'h8); chk("seq_instr2", ifc.instr, 32'h0109_5020); chk("seq_cnt2", fetch_count, 32'd2);

        // Backpressure: slot and pc hold.
        ifc.ready = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_pc", ifc.pc, 32'h8);
            chk("stall_instr", ifc.instr, 32'h0109_5020);
            chk("stall_addr", imem_addr, 32'hC);
            chk("stall_cnt", fetch_count, 32'd2);
        end
        ifc.ready = 1'b1;
        tick(); chk("resume_pc", ifc.pc, 32'hC); chk("resume_cnt", fetch_count, 32'd3);
        tick(); chk("pre_redir_pc", ifc.pc, 32'h10);

        // Redirect coincident with acceptance of the slot at 0x10.
        redirect_valid = 1'b1; redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
`ifdef IFETCH_DELAY_SLOT_EN
        chk("ds_valid", 32'(ifc.valid), 32'd1);
        chk("ds_pc", ifc.pc, 32'h14);
`else
        chk("squash_valid", 32'(ifc.valid), 32'd0);
`endif
        tick(); chk("redir_valid", 32'(ifc.valid), 32'd1); chk("redir_pc", ifc.pc, 32'h40);

        // Random backpressure and in-range redirects.
        repeat (400) begin
            ifc.ready       = ($urandom_range(0, 3) != 0);
            redirect_valid  = ($urandom_range(0, 9) == 0);
            redirect_target = {20'h0, 10'($urandom_range(0, 511)), 2'b00};
            tick();
        end
        ifc.ready = 1'b1; redirect_valid = 1'b0;
        tick();

        // Misaligned redirect enters sticky fault.
        redirect_valid = 1'b1; redirect_target = 32'h42;
        tick();
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_fault_pc", fault_pc, 32'h42);
        redirect_target = 32'h80;
        repeat (6) begin
            ifc.ready = ($urandom_range(0, 1) != 0);
            tick();
        end
        ifc.ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("fault_drained", 32'(ifc.valid), 32'd0);
        chk("fault_sticky_pc", fault_pc, 32'h42);

        // Asynchronous reset while stalled in FAULT.
        ifc.ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Run off the end of instruction memory.
        ifc.ready = 1'b1;
        n = 0;
        while (!fault && n < 1100) begin
            tick();
            n++;
        end
        chk("range_cycles", 32'(n), 32'd1024);
        chk("range_fault_pc", fault_pc, 32'h1000);
        chk("range_last_pc", ifc.pc, 32'hFFC);
        chk("range_last_valid", 32'(ifc.valid), 32'd1);
        tick();
        chk("range_drained", 32'(ifc.valid), 32'd0);
        chk("range_addr_hold", imem_addr, 32'hFFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
